id_ex_stage: RTL and testbench

- Pipeline register between decode and the execute ALU.
- Captures decoded operands and control fields, and resolves RAW hazards by forwarding from the EX and MEM stages.
- Inserts a one-cycle bubble on load-use hazards.
- Presents registered val1/val2/aluop/is_alu_op to the ALU and carries rd/write-enable/load flags downstream.

---
 rtl/id_ex_stage_pkg.sv | 18 +
 rtl/id_ex_stage_fwd_mux.sv | 30 +++
 rtl/id_ex_stage.sv | 112 +++++++++++
 tb/tb_id_ex_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths and ALU opcode encodings for the decode/execute boundary.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] ALUOP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] ALUOP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] ALUOP_AND  = 5'd2;
  localparam logic [OP_W-1:0] ALUOP_OR   = 5'd3;
  localparam logic [OP_W-1:0] ALUOP_XOR  = 5'd4;
  localparam logic [OP_W-1:0] ALUOP_SHL  = 5'd5;
  localparam logic [OP_W-1:0] ALUOP_SHR  = 5'd6;
  localparam logic [OP_W-1:0] ALUOP_MOVL = 5'd7;
  localparam logic [OP_W-1:0] ALUOP_MOVH = 5'd8;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Priority operand select: EX result, then MEM result, then register file.
module id_ex_stage_fwd_mux #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 4
) (
  input  logic [AW-1:0] rs,
  input  logic [W-1:0]  rf_val,
  input  logic          ex_valid,
  input  logic          ex_rd_we,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd,
  input  logic [W-1:0]  ex_result,
  input  logic          mem_valid,
  input  logic          mem_rd_we,
  input  logic [AW-1:0] mem_rd,
  input  logic [W-1:0]  mem_result,
  output logic [W-1:0]  val
);

  // A load in EX has no result yet; the hazard bubble covers that case.
  always_comb begin
    val = rf_val;
    if (ex_valid && ex_rd_we && !ex_is_load && (ex_rd == rs)) begin
      val = ex_result;
    end else if (mem_valid && mem_rd_we && (mem_rd == rs)) begin
      val = mem_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with forwarding and load-use bubbles.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OP_W-1:0]   id_aluop,
  input  logic              id_is_alu_op,
  input  logic              id_is_load,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [DATA_W-1:0] id_rs1_val,
  input  logic [DATA_W-1:0] id_rs2_val,
  input  logic              id_use_imm,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rd_we,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rd_we,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [OP_W-1:0]   ex_aluop,
  output logic              ex_is_alu_op,
  output logic              ex_is_load,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_rd_we
);

  logic              hazard;
  logic [DATA_W-1:0] fwd1;
  logic [DATA_W-1:0] fwd2;

  // Load in EX whose destination is a source of the decode instruction.
  assign hazard = ex_valid && ex_is_load && ex_rd_we &&
                  ((ex_rd == id_rs1) || (!id_use_imm && (ex_rd == id_rs2)));

  assign id_ready = !ex_stall && !hazard;

  id_ex_stage_fwd_mux #(.W(DATA_W), .AW(REG_AW)) u_fwd1 (
    .rs         (id_rs1),
    .rf_val     (id_rs1_val),
    .ex_valid   (ex_valid),
    .ex_rd_we   (ex_rd_we),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_result  (ex_result),
    .mem_valid  (mem_valid),
    .mem_rd_we  (mem_rd_we),
    .mem_rd     (mem_rd),
    .mem_result (mem_result),
    .val        (fwd1)
  );

  id_ex_stage_fwd_mux #(.W(DATA_W), .AW(REG_AW)) u_fwd2 (
    .rs         (id_rs2),
    .rf_val     (id_rs2_val),
    .ex_valid   (ex_valid),
    .ex_rd_we   (ex_rd_we),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_result  (ex_result),
    .mem_valid  (mem_valid),
    .mem_rd_we  (mem_rd_we),
    .mem_rd     (mem_rd),
    .mem_result (mem_result),
    .val        (fwd2)
  );

  // Flush beats stall beats capture; anything else inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_val1      <= '0;
      ex_val2      <= '0;
      ex_aluop     <= '0;
      ex_is_alu_op <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_rd        <= '0;
      ex_rd_we     <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_is_alu_op <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_rd_we     <= 1'b0;
    end else if (!ex_stall) begin
      if (id_valid && !hazard) begin
        ex_valid     <= 1'b1;
        ex_val1      <= fwd1;
        ex_val2      <= id_use_imm ? id_imm : fwd2;
        ex_aluop     <= id_aluop;
        ex_is_alu_op <= id_is_alu_op;
        ex_is_load   <= id_is_load;
        ex_rd        <= id_rd;
        ex_rd_we     <= id_rd_we;
      end else begin
        ex_valid     <= 1'b0;
        ex_is_alu_op <= 1'b0;
        ex_is_load   <= 1'b0;
        ex_rd_we     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic              id_ready;
  logic [OP_W-1:0]   id_aluop;
  logic              id_is_alu_op;
  logic              id_is_load;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [DATA_W-1:0] id_rs1_val;
  logic [DATA_W-1:0] id_rs2_val;
  logic              id_use_imm;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic [DATA_W-1:0] ex_result;
  logic              mem_valid;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_rd_we;
  logic [DATA_W-1:0] mem_result;
  logic              ex_stall;
  logic              flush;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_val1;
  logic [DATA_W-1:0] ex_val2;
  logic [OP_W-1:0]   ex_aluop;
  logic              ex_is_alu_op;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_rd_we;

  int errors = 0;
  int checks = 0;

  // Model of what the stage should be holding.
  logic              m_valid, m_alu, m_load, m_we;
  logic [DATA_W-1:0] m_val1, m_val2;
  logic [OP_W-1:0]   m_op;
  logic [REG_AW-1:0] m_rd;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_aluop), .id_is_alu_op(id_is_alu_op), .id_is_load(id_is_load),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_val(id_rs1_val),
    .id_rs2_val(id_rs2_val), .id_use_imm(id_use_imm), .id_imm(id_imm),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .ex_result(ex_result),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_rd_we(mem_rd_we),
    .mem_result(mem_result), .ex_stall(ex_stall), .flush(flush),
    .ex_valid(ex_valid), .ex_val1(ex_val1), .ex_val2(ex_val2),
    .ex_aluop(ex_aluop), .ex_is_alu_op(ex_is_alu_op), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] rs, input logic [DATA_W-1:0] rf);
    if (m_valid && m_we && !m_load && m_rd == rs) return ex_result;
    if (mem_valid && mem_rd_we && mem_rd == rs) return mem_result;
    return rf;
  endfunction

  function automatic logic model_hazard();
    return m_valid && m_load && m_we &&
           ((m_rd == id_rs1) || (!id_use_imm && m_rd == id_rs2));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_alu = 0; m_load = 0; m_we = 0;
    m_val1 = '0; m_val2 = '0; m_op = '0; m_rd = '0;
  endtask

  // Apply one clock edge's worth of the stage's rules to the model.
  task automatic model_edge();
    logic [DATA_W-1:0] v1, v2;
    logic hz;
    hz = model_hazard();
    v1 = fwd(id_rs1, id_rs1_val);
    v2 = id_use_imm ? id_imm : fwd(id_rs2, id_rs2_val);
    if (flush) begin
      m_valid = 0; m_we = 0; m_alu = 0;
    end else if (ex_stall) begin
      // hold
    end else if (id_valid && !hz) begin
      m_valid = 1; m_val1 = v1; m_val2 = v2; m_op = id_aluop;
      m_alu = id_is_alu_op; m_load = id_is_load; m_rd = id_rd; m_we = id_rd_we;
    end else begin
      m_valid = 0; m_we = 0; m_alu = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".rd_we"}, 32'(ex_rd_we), 32'(m_we));
    chk({tag, ".is_alu"}, 32'(ex_is_alu_op), 32'(m_alu));
    if (m_valid) begin
      chk({tag, ".val1"}, ex_val1, m_val1);
      chk({tag, ".val2"}, ex_val2, m_val2);
      chk({tag, ".aluop"}, 32'(ex_aluop), 32'(m_op));
      chk({tag, ".is_load"}, 32'(ex_is_load), 32'(m_load));
      chk({tag, ".rd"}, 32'(ex_rd), 32'(m_rd));
    end
  endtask

  // Check ready before the edge, clock, then check the new contents.
  task automatic step(input string tag);
    #1;
    chk({tag, ".ready"}, 32'(id_ready), 32'(!ex_stall && !model_hazard()));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive_id(input logic v, input logic [OP_W-1:0] op, input logic load,
                          input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                          input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                          input logic imm_sel, input logic [DATA_W-1:0] imm,
                          input logic [REG_AW-1:0] rd);
    id_valid = v; id_aluop = op; id_is_alu_op = !load; id_is_load = load;
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_val = v1; id_rs2_val = v2;
    id_use_imm = imm_sel; id_imm = imm; id_rd = rd; id_rd_we = 1'b1;
  endtask

  task automatic drive_mem(input logic v, input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] res);
    mem_valid = v; mem_rd = rd; mem_rd_we = v; mem_result = res;
  endtask

  initial begin
    rst = 1'b1; ex_stall = 0; flush = 0; ex_result = '0;
    drive_id(0, ALUOP_ADD, 0, 0, 0, '0, '0, 0, '0, 0);
    drive_mem(0, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check_outputs("reset");
    chk("reset.val1", ex_val1, 32'h0);
    chk("reset.ready", 32'(id_ready), 32'h1);

    // Back-to-back dependency through EX.
    drive_id(1, ALUOP_ADD, 0, 1, 2, 32'h1, 32'h2, 0, '0, 3);
    step("b2b.i1");
    ex_result = 32'h10;
    drive_id(1, ALUOP_ADD, 0, 3, 3, 32'hDEAD, 32'hDEAD, 0, '0, 4);
    step("b2b.i2");
    chk("b2b.val1", ex_val1, 32'h10);
    chk("b2b.val2", ex_val2, 32'h10);

    // EX beats MEM, then MEM alone when EX is empty.
    drive_id(1, ALUOP_ADD, 0, 1, 1, '0, '0, 0, '0, 5);
    step("pri.prod");
    ex_result = 32'h1; drive_mem(1, 5, 32'h2);
    drive_id(1, ALUOP_SUB, 0, 5, 0, 32'hBAD, 32'h0, 0, '0, 6);
    step("pri.ex");
    chk("pri.ex_wins", ex_val1, 32'h1);
    drive_id(0, ALUOP_ADD, 0, 0, 0, '0, '0, 0, '0, 0); drive_mem(0, 0, '0);
    step("pri.bubble");
    drive_mem(1, 5, 32'h2);
    drive_id(1, ALUOP_OR, 0, 5, 0, 32'hBAD, 32'h0, 0, '0, 6);
    step("pri.mem");
    chk("pri.mem_wins", ex_val1, 32'h2);

    // Load-use: one bubble then forward from MEM.
    drive_mem(0, 0, '0);
    drive_id(1, ALUOP_ADD, 1, 0, 0, '0, '0, 1, 32'h40, 2);
    step("lu.load");
    drive_id(1, ALUOP_ADD, 0, 2, 1, 32'hDEAD, 32'h7, 0, '0, 8);
    #1 chk("lu.ready_low", 32'(id_ready), 32'h0);
    step("lu.bubble");
    chk("lu.bubble_valid", 32'(ex_valid), 32'h0);
    drive_mem(1, 2, 32'hCAFE);
    step("lu.cap");
    chk("lu.val1", ex_val1, 32'hCAFE);

    // Stall three cycles, then flush during a stall.
    drive_mem(0, 0, '0);
    ex_stall = 1;
    drive_id(1, ALUOP_XOR, 0, 9, 10, 32'h99, 32'hAA, 0, '0, 11);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.held_val1", ex_val1, 32'hCAFE);
    end
    flush = 1;
    step("flush");
    chk("flush.valid", 32'(ex_valid), 32'h0);
    flush = 0; ex_stall = 0;
    drive_id(0, ALUOP_ADD, 0, 0, 0, '0, '0, 0, '0, 0);
    step("flush.after");
    chk("flush.dropped", 32'(ex_valid), 32'h0);

    // Immediate operand ignores rs2 forwarding.
    drive_id(1, ALUOP_ADD, 0, 1, 1, '0, '0, 0, '0, 7);
    step("imm.prod");
    ex_result = 32'hAAAA;
    drive_id(1, ALUOP_MOVH, 0, 0, 7, 32'h0, 32'h5555, 1, 32'h12345678, 9);
    step("imm.movh");
    chk("imm.val2", ex_val2, 32'h12345678);

    // Asynchronous reset while holding a valid instruction.
    chk("arst.pre_valid", 32'(ex_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("arst");
    chk("arst.val1", ex_val1, 32'h0);
    chk("arst.val2", ex_val2, 32'h0);
    chk("arst.rd", 32'(ex_rd), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); model_edge(); #1;

    // Random traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom_range(0, 3) != 0);
      id_aluop     = OP_W'($urandom_range(0, 8));
      id_is_alu_op = 1'($urandom);
      id_is_load   = ($urandom_range(0, 3) == 0);
      id_rs1       = REG_AW'($urandom_range(0, 3));
      id_rs2       = REG_AW'($urandom_range(0, 3));
      id_rs1_val   = $urandom;
      id_rs2_val   = $urandom;
      id_use_imm   = ($urandom_range(0, 3) == 0);
      id_imm       = $urandom;
      id_rd        = REG_AW'($urandom_range(0, 3));
      id_rd_we     = ($urandom_range(0, 4) != 0);
      ex_result    = $urandom;
      mem_valid    = 1'($urandom);
      mem_rd       = REG_AW'($urandom_range(0, 3));
      mem_rd_we    = 1'($urandom);
      mem_result   = $urandom;
      ex_stall     = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
